// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: payload width/type and the FIFO pointer-width helper.
package xbar_pkg;

    localparam int unsigned XBAR_PLD_W = 4;

    typedef logic [XBAR_PLD_W-1:0] xbar_pld_t;

    // Index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xbar_fifo_ctrl.sv
// Pointer/occupancy controller for xbar_dst_fifo: wrap-bit pointers, full/empty and the cnt register.
module xbar_fifo_ctrl
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             wr_en_o,
    output logic [CNT_W-2:0] wr_idx_o,
    output logic [CNT_W-2:0] rd_idx_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_en;

    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (wptr_q[CNT_W-2:0] == rptr_q[CNT_W-2:0]) &&
                      (wptr_q[CNT_W-1] != rptr_q[CNT_W-1]);
    assign wr_en_o  = push_i & ~full_o;
    assign rd_en    = pop_i & ~empty_o;
    assign wr_idx_o = wptr_q[CNT_W-2:0];
    assign rd_idx_o = rptr_q[CNT_W-2:0];
    assign cnt_o    = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en_o) wptr_d = wptr_q + CNT_W'(1);
        if (rd_en)   rptr_d = rptr_q + CNT_W'(1);
        case ({wr_en_o, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/xbar_dst_fifo.sv
// Per-destination crossbar egress FIFO; rdy_src_o depends on registered state only.
// Define XBAR_DST_FIFO_BYPASS_EN for zero-latency cut-through while empty.
module xbar_dst_fifo
    import xbar_pkg::*;
#(
    parameter int unsigned PLD_W = XBAR_PLD_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_src_i,
    input  logic [PLD_W-1:0] pld_src_i,
    output logic             rdy_src_o,
    output logic             vld_dst_o,
    output logic [PLD_W-1:0] pld_dst_o,
    input  logic             rdy_dst_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [PLD_W-1:0] mem_q [DEPTH];
    logic             push_req;
    logic             wr_en;
    logic [CNT_W-2:0] wr_idx;
    logic [CNT_W-2:0] rd_idx;
    logic             empty;
    logic             full;

    xbar_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push_req),
        .pop_i    (rdy_dst_i),
        .wr_en_o  (wr_en),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .empty_o  (empty),
        .full_o   (full),
        .cnt_o    (cnt_o)
    );

    assign rdy_src_o = ~full;

    always_comb begin
        push_req  = vld_src_i;
        vld_dst_o = ~empty;
        pld_dst_o = mem_q[rd_idx];
`ifdef XBAR_DST_FIFO_BYPASS_EN
        if (empty) begin
            vld_dst_o = vld_src_i;
            pld_dst_o = pld_src_i;
            // A beat consumed the same cycle it arrives never touches storage.
            push_req  = vld_src_i & ~rdy_dst_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= pld_src_i;
        end
    end

endmodule

// File: tb/tb_xbar_dst_fifo.sv
// Self-checking bench for xbar_dst_fifo: directed vector table, reset/stream sequences and
// randomized traffic against a queue-based reference model.
module tb_xbar_dst_fifo;

    localparam int DEPTH = 4;
    localparam int PLD_W = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             vld_src;
    logic [PLD_W-1:0] pld_src;
    logic             rdy_src;
    logic             vld_dst;
    logic [PLD_W-1:0] pld_dst;
    logic             rdy_dst;
    logic [CNT_W-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PLD_W-1:0] q[$];

    xbar_dst_fifo #(
        .PLD_W (PLD_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_src_i (vld_src),
        .pld_src_i (pld_src),
        .rdy_src_o (rdy_src),
        .vld_dst_o (vld_dst),
        .pld_dst_o (pld_dst),
        .rdy_dst_i (rdy_dst),
        .cnt_o     (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [PLD_W-1:0] p;
        logic             r;
        logic             ev;
        logic [PLD_W-1:0] ep;
        logic             erdy;
        int               ecnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        vld_src = 1'b0;
        pld_src = '0;
        rdy_dst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic checked against the reference queue, then the queue is advanced.
    task automatic cycle(input logic v, input logic [PLD_W-1:0] p, input logic r,
                         output logic acc);
        logic             ev;
        logic [PLD_W-1:0] ep;
        logic             erdy;
        logic             push;
        logic             pop;
        vld_src = v;
        pld_src = p;
        rdy_dst = r;
        @(negedge clk);
        ev = 1'b0;
        ep = '0;
        if (q.size() > 0) begin
            ev = 1'b1;
            ep = q[0];
        end
`ifdef XBAR_DST_FIFO_BYPASS_EN
        else begin
            ev = v;
            ep = p;
        end
`endif
        erdy = (q.size() < DEPTH);
        chk("vld_dst", int'(vld_dst), int'(ev));
        if (ev) chk("pld_dst", int'(pld_dst), int'(ep));
        chk("rdy_src", int'(rdy_src), int'(erdy));
        chk("cnt", int'(cnt), q.size());
        push = v && erdy;
        pop  = ev && r;
        if (q.size() == 0 && push && pop) begin
            // cut-through: nothing stored
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(p);
        end
        acc = push;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             acc;
        logic             hold;
        logic             cur_v;
        logic [PLD_W-1:0] cur_p;
        logic             r;

        // v, p, r, exp vld_dst, exp pld_dst, exp rdy_src, exp cnt (sampled before the edge)
        tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 0};
        tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 4'h1, 1'b1, 1};
        tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 4'h1, 1'b1, 2};
        tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 4'h1, 1'b1, 3};
        tbl[4]  = '{1'b1, 4'h5, 1'b0, 1'b1, 4'h1, 1'b0, 4};
        tbl[5]  = '{1'b1, 4'h5, 1'b1, 1'b1, 4'h1, 1'b0, 4};
        tbl[6]  = '{1'b1, 4'h5, 1'b0, 1'b1, 4'h2, 1'b1, 3};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 4};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, 3};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 2};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 1'b1, 1};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 0};
`ifdef XBAR_DST_FIFO_BYPASS_EN
        tbl[0].ev = 1'b1;
        tbl[0].ep = 4'h1;
`endif

        // Reset state
        rst_n   = 1'b0;
        vld_src = 1'b0;
        pld_src = '0;
        rdy_dst = 1'b0;
        #3;
        chk("reset_vld_dst", int'(vld_dst), 0);
        chk("reset_pld_dst", int'(pld_dst), 0);
        chk("reset_rdy_src", int'(rdy_src), 1);
        chk("reset_cnt", int'(cnt), 0);
        do_reset();

        // Fill to full, hold a 5th beat, single pop, then drain
        for (int i = 0; i < 12; i++) begin
            vld_src = tbl[i].v;
            pld_src = tbl[i].p;
            rdy_dst = tbl[i].r;
            @(negedge clk);
            chk($sformatf("tbl%0d_vld_dst", i), int'(vld_dst), int'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_pld_dst", i), int'(pld_dst), int'(tbl[i].ep));
            chk($sformatf("tbl%0d_rdy_src", i), int'(rdy_src), int'(tbl[i].erdy));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].ecnt);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-traffic
        do_reset();
        cycle(1'b1, 4'h7, 1'b0, acc);
        cycle(1'b1, 4'h8, 1'b0, acc);
        cycle(1'b1, 4'h9, 1'b0, acc);
        vld_src = 1'b0;
        pld_src = '0;
        rdy_dst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vld_dst", int'(vld_dst), 0);
        chk("midrst_cnt", int'(cnt), 0);
        chk("midrst_rdy_src", int'(rdy_src), 1);
        chk("midrst_pld_dst", int'(pld_dst), 0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1, acc);

        // Streaming 0x0..0xF with both sides always ready
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, PLD_W'(i), 1'b1, acc);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'h0, 1'b1, acc);

`ifdef XBAR_DST_FIFO_BYPASS_EN
        // Cut-through, then stored beat under backpressure
        do_reset();
        cycle(1'b1, 4'hA, 1'b1, acc);
        cycle(1'b1, 4'hA, 1'b0, acc);
        cycle(1'b0, 4'h0, 1'b0, acc);
        cycle(1'b0, 4'h0, 1'b1, acc);
`endif

        // Randomized traffic with wrap-around; the source holds an unaccepted beat
        do_reset();
        hold  = 1'b0;
        cur_v = 1'b0;
        cur_p = '0;
        for (int i = 0; i < 300; i++) begin
            if (!hold) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_p = PLD_W'($urandom);
            end
            if (i < 100) r = ($urandom_range(0, 3) == 0);
            else if (i < 200) r = ($urandom_range(0, 1) == 0);
            else r = ($urandom_range(0, 3) != 0);
            cycle(cur_v, cur_p, r, acc);
            hold = cur_v && !acc;
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 4'h0, 1'b1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_dst_fifo.md
# xbar_dst_fifo

- Per-destination egress buffer for the N-to-M crossbar; one instance sits directly downstream of each N-to-1 arbitrating mux output.
- Decouples the arbiter's `rdy_dst` from downstream backpressure by absorbing granted beats in a small FIFO.
- Valid/ready on both sides. `rdy_src` never depends combinationally on `rdy_dst`, which breaks the long ready path back through the arbiter and the 1-to-M demuxes.

## Interface
Parameters:
- `PLD_W`, default 4: payload width; matches the crossbar payload.
- `DEPTH`, default 4: entries. Must be a power of two, ≥2.
- `CNT_W`, default $clog2(DEPTH)+1: occupancy width (derived; not overridden).

Ports:
- `clk`, input, 1: single clock. All state is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `vld_src`, input, 1: beat offered by the arbiter.
- `pld_src`, input, PLD_W: payload from the arbiter.
- `rdy_src`, output, 1: FIFO can accept a beat.
- `vld_dst`, output, 1: beat available downstream.
- `pld_dst`, output, PLD_W: payload to downstream.
- `rdy_dst`, input, 1: downstream accepts.
- `cnt`, output, CNT_W: current occupancy, 0..DEPTH.

## Operation
- push = `vld_src & rdy_src`; pop = `vld_dst & rdy_dst`. A beat transfers only on a cycle where both signals are high at the clock edge.
- Storage: `DEPTH` × `PLD_W` register array.
  - Write pointer `wptr` and read pointer `rptr` are each CNT_W bits wide; the MSB is a wrap bit.
  - empty = (wptr == rptr).
  - full = index bits equal and wrap bits differ.
- `rdy_src` = !full. It is a function of registered state only.
- `vld_dst` = !empty; `pld_dst` = mem[rptr index] (default, non-bypass build).
- Push writes `pld_src` at the wptr index, then wptr+1. Pop advances rptr+1. Pointers wrap naturally modulo 2·DEPTH.
- `cnt` is a register:
  - +1 on push only, −1 on pop only.
  - Unchanged on push+pop, and unchanged when neither occurs.
- Simultaneous push and pop at a partial level: both pointers advance and `cnt` holds.
- Full: `rdy_src`=0. A pop that cycle frees one slot; `rdy_src` rises the next cycle.
  - There is no same-cycle refill when full, by design.
- Empty: `vld_dst`=0 (non-bypass). A push becomes visible the next cycle.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- Source rule: `pld_src` must hold while `vld_src`=1 and `rdy_src`=0.
- Destination guarantee: `vld_dst`/`pld_dst` stay stable until popped.
- Reset, including mid-operation: all contents are discarded immediately.
  - wptr=rptr=0, `cnt`=0, memory cleared to 0.
  - Reset values: `vld_dst`=0, `pld_dst`=0, `rdy_src`=1.

## Timing
- Latency (non-bypass): push at edge k → `vld_dst`=1 after edge k, so the beat can be popped at edge k+1.
- Throughput: one beat per cycle sustained in and out when 0 < cnt < DEPTH.
- Combinational paths:
  - None from `rdy_dst` to `rdy_src`.
  - None from `vld_src` to `vld_dst` (non-bypass).
- `cnt` reflects the state after the last edge.

## Configuration
- Macro: `XBAR_DST_FIFO_BYPASS_EN`.
- Defined: cut-through when empty.
  - When empty, `vld_dst` = `vld_src` and `pld_dst` = `pld_src` combinationally.
  - Empty & vld_src & rdy_dst: the beat passes straight through; nothing is written, pointers and `cnt` are unchanged. Zero-cycle latency.
  - Empty & vld_src & !rdy_dst: the beat is written normally. Next cycle `vld_dst`=1 with the same payload, so the stability guarantee holds.
  - `rdy_src` is still !full; there is still no `rdy_dst`→`rdy_src` path.
- Undefined: pure registered FIFO, one-cycle minimum latency, as described in Operation.

## Structure
- Shared package `xbar_pkg`:
  - `XBAR_PLD_W` (=4), used as the `PLD_W` default.
  - Typedef `xbar_pld_t` (logic [XBAR_PLD_W-1:0]).
  - A `clog2`-based pointer-width helper.
- One sub-module, `xbar_fifo_ctrl`:
  - Holds pointers, full/empty and the `cnt` register.
  - Emits the write enable, write index and read index.
  - The top keeps the memory array and the bypass mux.

## Test plan
- Reset mid-traffic: fill 3 beats, pulse `rst_n` low asynchronously between edges → immediately `vld_dst`=0, `cnt`=0, `rdy_src`=1; old data never appears after release.
- Fill to full, `rdy_dst`=0, push 0x1,0x2,0x3,0x4 → `cnt`=4, `rdy_src`=0; a 5th offered beat 0x5 is held, not accepted. Then drain → output 0x1..0x4 in order.
- Full with one pop: `rdy_dst`=1 for one cycle → `cnt`=3, `rdy_src`=1 the next cycle, not the same cycle.
- Streaming: `vld_src`=`rdy_dst`=1 continuously with payloads 0x0..0xF → 16 beats out in order, one per cycle, `cnt` constant at 1 (non-bypass) / 0 (bypass).
- Wrap-around: push/pop 2·DEPTH+3 beats at random backpressure → scoreboard exact order, `cnt` always equals pushes−pops.
- Bypass build, empty, `vld_src`=1, `pld_src`=0xA, `rdy_dst`=1 → `vld_dst`=1 and `pld_dst`=0xA in the same cycle, `cnt` stays 0. With `rdy_dst`=0 → `cnt`=1 and 0xA is held stable next cycle.
